// File: rtl/sample_logic_pkg.sv
// Shared types and truth-table constants for the 3-input function evaluator.
package sample_logic_pkg;

    typedef logic [7:0] tt_t;
    typedef logic [2:0] idx_t;

    localparam tt_t TT_MAJORITY = 8'hE8;
    localparam tt_t TT_XOR3     = 8'h96;
    localparam tt_t TT_AND3     = 8'h80;
    localparam tt_t TT_OR3      = 8'hFE;

endpackage

// File: rtl/sample_logic_cov.sv
// Minterm coverage bitmap and saturating counter of output transitions.
module sample_logic_cov
    import sample_logic_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  idx_t             eval_idx,
    input  logic             cov_clr,
    input  logic             f_cur,
    input  logic             f_next,
    output logic [7:0]       cov,
    output logic             all_seen,
    output logic [CNT_W-1:0] tog_cnt
);

    logic toggle;

    assign toggle   = (f_next != f_cur);
    assign all_seen = (cov == 8'hFF);

    // Clear beats the same-cycle mark and the same-cycle toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cov     <= 8'h00;
            tog_cnt <= '0;
        end else if (cov_clr) begin
            cov     <= 8'h00;
            tog_cnt <= '0;
        end else begin
            cov[eval_idx] <= 1'b1;
            if (toggle && (tog_cnt != {CNT_W{1'b1}}))
                tog_cnt <= tog_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sample_logic.sv
// Registered, programmable 3-input Boolean function evaluator with
// minterm coverage tracking.
module sample_logic
    import sample_logic_pkg::*;
#(
    parameter tt_t DEFAULT_TT = TT_MAJORITY,
    parameter int  CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_tt,
    input  logic             cov_clr,
    output logic             f,
    output logic             f_comb,
    output logic [2:0]       idx,
    output logic [7:0]       tt,
    output logic [7:0]       cov,
    output logic             all_seen,
    output logic [CNT_W-1:0] tog_cnt
);

    tt_t  tt_q;
    idx_t eval_idx;

    assign eval_idx = {a, b, c};
    assign f_comb   = tt_q[eval_idx];
    assign tt       = tt_q;

    // The lookup feeding f uses the table held before any same-edge load.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q <= DEFAULT_TT;
            f    <= 1'b0;
            idx  <= 3'd0;
        end else begin
            f   <= f_comb;
            idx <= eval_idx;
            if (cfg_we)
                tt_q <= cfg_tt;
        end
    end

    sample_logic_cov #(
        .CNT_W (CNT_W)
    ) u_cov (
        .clk      (clk),
        .rst      (rst),
        .eval_idx (eval_idx),
        .cov_clr  (cov_clr),
        .f_cur    (f),
        .f_next   (f_comb),
        .cov      (cov),
        .all_seen (all_seen),
        .tog_cnt  (tog_cnt)
    );

endmodule

// File: tb/tb_sample_logic.sv
// Self-checking bench for sample_logic: reference model feeds a scoreboard
// queue at drive time, entries are compared after each clock edge.
module tb_sample_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_tt = 8'h00;
    logic       cov_clr = 1'b0;
    logic       f, f_comb, all_seen;
    logic [2:0] idx;
    logic [7:0] tt, cov, tog_cnt;

    typedef struct packed {
        logic       f;
        logic [2:0] idx;
        logic [7:0] cov;
        logic [7:0] tog;
        logic [7:0] tt;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [7:0] m_tt;
    logic       m_f;
    logic [2:0] m_idx;
    logic [7:0] m_cov;
    logic [7:0] m_tog;

    int checks = 0;
    int errors = 0;

    sample_logic #(.DEFAULT_TT(8'hE8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .cfg_we   (cfg_we),
        .cfg_tt   (cfg_tt),
        .cov_clr  (cov_clr),
        .f        (f),
        .f_comb   (f_comb),
        .idx      (idx),
        .tt       (tt),
        .cov      (cov),
        .all_seen (all_seen),
        .tog_cnt  (tog_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, push the model's post-edge state, advance past the edge.
    task automatic drive(input logic [2:0] abc, input logic we, input logic [7:0] cfg,
                         input logic clr, input logic r);
        logic nf;
        {a, b, c} = abc;
        cfg_we  = we;
        cfg_tt  = cfg;
        cov_clr = clr;
        rst     = r;
        if (r) begin
            m_tt = 8'hE8; m_f = 1'b0; m_idx = 3'd0; m_cov = 8'h00; m_tog = 8'h00;
        end else begin
            nf = m_tt[abc];
            if (clr) begin
                m_cov = 8'h00;
                m_tog = 8'h00;
            end else begin
                m_cov[abc] = 1'b1;
                if (nf != m_f && m_tog != 8'hFF) m_tog = m_tog + 8'd1;
            end
            m_f   = nf;
            m_idx = abc;
            if (we) m_tt = cfg;
        end
        sb.push_back('{m_f, m_idx, m_cov, m_tog, m_tt});
        @(posedge clk);
        #1;
        {cfg_we, cov_clr, rst} = 3'b000;
    endtask

    task automatic test_reset();
        drive(3'd5, 1'b1, 8'h11, 1'b1, 1'b1);
        drive(3'd6, 1'b0, 8'h00, 1'b0, 1'b1);
        void'(sb.pop_front());
        e = sb.pop_front();
        checks++;
        if ({f, idx, cov, tog_cnt, tt} !== {1'b0, 3'd0, 8'h00, 8'h00, 8'hE8}) begin
            errors++;
            $display("FAIL reset_state got f=%0b idx=%0d cov=%h tog=%0d tt=%h want 0 0 00 0 e8",
                     f, idx, cov, tog_cnt, tt);
        end
        checks++;
        if (all_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_all_seen got %0b want 0", all_seen);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] maj = 8'hE8;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({f, idx, cov, tog_cnt, tt} !== e || f !== maj[i]) begin
                errors++;
                $display("FAIL sweep_%0d got f=%0b idx=%0d cov=%h tog=%0d tt=%h want f=%0b idx=%0d cov=%h tog=%0d tt=%h",
                         i, f, idx, cov, tog_cnt, tt, e.f, e.idx, e.cov, e.tog, e.tt);
            end
        end
        checks++;
        if (cov !== 8'hFF || all_seen !== 1'b1) begin
            errors++;
            $display("FAIL sweep_cover got cov=%h all_seen=%0b want ff 1", cov, all_seen);
        end
    endtask

    task automatic test_cfg_update();
        drive(3'b001, 1'b1, 8'h96, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (f !== 1'b0 || f_comb !== 1'b1 || tt !== 8'h96 || f !== e.f) begin
            errors++;
            $display("FAIL cfg_same_edge got f=%0b f_comb=%0b tt=%h want f=0 f_comb=1 tt=96",
                     f, f_comb, tt);
        end
        drive(3'b001, 1'b0, 8'h00, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (f !== 1'b1 || {f, idx, cov, tog_cnt, tt} !== e) begin
            errors++;
            $display("FAIL cfg_next_edge got f=%0b idx=%0d cov=%h tog=%0d want f=1 idx=%0d cov=%h tog=%0d",
                     f, idx, cov, tog_cnt, e.idx, e.cov, e.tog);
        end
    endtask

    task automatic test_toggle_sat();
        int bad = 0;
        drive(3'b000, 1'b1, 8'hE8, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 3'b111 : 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            if ({f, idx, cov, tog_cnt, tt} !== e) begin
                if (bad == 0)
                    $display("FAIL toggle_cycle_%0d got f=%0b tog=%0d cov=%h want f=%0b tog=%0d cov=%h",
                             i, f, tog_cnt, cov, e.f, e.tog, e.cov);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (tog_cnt !== 8'd255) begin
            errors++;
            $display("FAIL toggle_saturate got %0d want 255", tog_cnt);
        end
    endtask

    task automatic test_cov_clear();
        for (int i = 0; i < 8; i++) drive(3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) void'(sb.pop_front());
        drive(3'b101, 1'b0, 8'h00, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (cov !== 8'h00 || tog_cnt !== 8'd0 || all_seen !== 1'b0) begin
            errors++;
            $display("FAIL cov_clear got cov=%h tog=%0d all_seen=%0b want 00 0 0", cov, tog_cnt, all_seen);
        end
        drive(3'b101, 1'b0, 8'h00, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (cov !== 8'h20 || {f, idx, cov, tog_cnt, tt} !== e) begin
            errors++;
            $display("FAIL cov_remark got cov=%h tog=%0d want cov=20 tog=%0d", cov, tog_cnt, e.tog);
        end
    endtask

    task automatic test_reset_mid();
        drive(3'd0, 1'b1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) drive(3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) void'(sb.pop_front());
        drive(3'd7, 1'b0, 8'h00, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({f, idx, cov, tog_cnt, tt} !== {1'b0, 3'd0, 8'h00, 8'h00, 8'hE8}) begin
            errors++;
            $display("FAIL reset_mid got f=%0b idx=%0d cov=%h tog=%0d tt=%h want 0 0 00 0 e8",
                     f, idx, cov, tog_cnt, tt);
        end
        drive(3'd7, 1'b1, 8'h00, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (tt !== 8'hE8 || f !== 1'b0 || cov !== 8'h00) begin
            errors++;
            $display("FAIL reset_blocks_cfg got tt=%h f=%0b cov=%h want e8 0 00", tt, f, cov);
        end
    endtask

    task automatic test_const_tables();
        int bad = 0;
        drive(3'd0, 1'b1, 8'h00, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            if (f !== 1'b0 || {f, idx, cov, tog_cnt, tt} !== e) bad++;
        end
        checks++;
        if (bad != 0 || tog_cnt !== 8'd0) begin
            errors++;
            $display("FAIL const_zero got bad=%0d tog=%0d want 0 0", bad, tog_cnt);
        end
        bad = 0;
        drive(3'd7, 1'b1, 8'hFF, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
            e = sb.pop_front();
            if (f !== 1'b1 || {f, idx, cov, tog_cnt, tt} !== e) bad++;
        end
        checks++;
        if (bad != 0 || tog_cnt !== 8'd1) begin
            errors++;
            $display("FAIL const_one got bad=%0d tog=%0d want 0 1", bad, tog_cnt);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_sweep();
        test_cfg_update();
        test_toggle_sat();
        test_cov_clear();
        test_reset_mid();
        test_const_tables();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
